// File: rtl/rtc_pkg.sv
// Shared RTC constants and state encodings for the scan/alarm controller.
package rtc_pkg;
   localparam int         RTC_AW         = 7;
   localparam logic [6:0] RTC_INIT_ADDR  = 7'h02;
   localparam logic [6:0] RTC_SEG0_FIRST = 7'h21;
   localparam logic [6:0] RTC_SEG0_LAST  = 7'h26;
   localparam logic [6:0] RTC_SEG1_FIRST = 7'h41;
   localparam logic [6:0] RTC_SEG1_LAST  = 7'h43;

   typedef enum logic [1:0] {S_INIT, S_REQ, S_ADV, S_WAIT} scan_st_e;
   typedef enum logic       {A_IDLE, A_ON}                  alarm_st_e;

   // Counter width able to hold the parameter value itself.
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction
endpackage

// File: rtl/rtc_addr_step.sv
// One-step address move across the two register segments, wrapping between them.
module rtc_addr_step
   import rtc_pkg::*;
#(
   parameter int            AW         = RTC_AW,
   parameter logic [AW-1:0] SEG0_FIRST = AW'(RTC_SEG0_FIRST),
   parameter logic [AW-1:0] SEG0_LAST  = AW'(RTC_SEG0_LAST),
   parameter logic [AW-1:0] SEG1_FIRST = AW'(RTC_SEG1_FIRST),
   parameter logic [AW-1:0] SEG1_LAST  = AW'(RTC_SEG1_LAST)
) (
   input  logic [AW-1:0] i_addr,
   input  logic          i_dn,
   output logic [AW-1:0] o_next
);
   always_comb begin
      o_next = i_addr;
      if (!i_dn) begin
         if (i_addr == SEG0_LAST)      o_next = SEG1_FIRST;
         else if (i_addr == SEG1_LAST) o_next = SEG0_FIRST;
         else                          o_next = i_addr + AW'(1);
      end else begin
         if (i_addr == SEG0_FIRST)      o_next = SEG1_LAST;
         else if (i_addr == SEG1_FIRST) o_next = SEG0_LAST;
         else                           o_next = i_addr - AW'(1);
      end
   end
endmodule

// File: rtl/rtc_scan_ctrl.sv
// RTC register scanner: init write, periodic two-segment scan, edit cursor and alarm timer.
module rtc_scan_ctrl
   import rtc_pkg::*;
#(
   parameter int            AW         = RTC_AW,
   parameter logic [AW-1:0] INIT_ADDR  = AW'(RTC_INIT_ADDR),
   parameter logic [AW-1:0] SEG0_FIRST = AW'(RTC_SEG0_FIRST),
   parameter logic [AW-1:0] SEG0_LAST  = AW'(RTC_SEG0_LAST),
   parameter logic [AW-1:0] SEG1_FIRST = AW'(RTC_SEG1_FIRST),
   parameter logic [AW-1:0] SEG1_LAST  = AW'(RTC_SEG1_LAST),
   parameter int            WAIT_CYC   = 5,
   parameter int            ALARM_CYC  = 3
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          i_done,
   input  logic          i_irq,
   input  logic          i_btn_left,
   input  logic          i_btn_right,
   input  logic          i_btn_commit,
   input  logic          i_btn_ack,
   output logic          o_req,
   output logic          o_wr,
   output logic [AW-1:0] o_addr,
   output logic [AW-1:0] o_cursor,
   output logic          o_scan_done,
   output logic          o_alarm,
   output logic          o_stw
);
   localparam int            WCW        = cnt_w(WAIT_CYC);
   localparam int            ACW        = cnt_w(ALARM_CYC);
   localparam logic [WCW-1:0] WAIT_LAST  = WCW'(WAIT_CYC - 1);
   localparam logic [ACW-1:0] ALARM_LAST = ACW'(ALARM_CYC - 1);

   scan_st_e       r_st, w_st;
   alarm_st_e      r_ast, w_ast;
   logic [AW-1:0]  r_addr, w_addr, r_cursor, w_cursor;
   logic [AW-1:0]  w_addr_inc, w_cur_step;
   logic           r_req, w_req, r_wr, w_wr, r_pend, w_pend, r_sdone, w_sdone;
   logic           r_alarm, w_alarm, r_stw, w_stw, r_ack, w_ack;
   logic [WCW-1:0] r_wcnt, w_wcnt;
   logic [ACW-1:0] r_acnt, w_acnt;
   logic           w_done;

   rtc_addr_step #(.AW(AW), .SEG0_FIRST(SEG0_FIRST), .SEG0_LAST(SEG0_LAST),
                   .SEG1_FIRST(SEG1_FIRST), .SEG1_LAST(SEG1_LAST))
   u_scan_step (.i_addr(r_addr), .i_dn(1'b0), .o_next(w_addr_inc));

   rtc_addr_step #(.AW(AW), .SEG0_FIRST(SEG0_FIRST), .SEG0_LAST(SEG0_LAST),
                   .SEG1_FIRST(SEG1_FIRST), .SEG1_LAST(SEG1_LAST))
   u_cur_step (.i_addr(r_cursor), .i_dn(i_btn_right), .o_next(w_cur_step));

   // A done arriving while no request is outstanding belongs to nothing.
   assign w_done = i_done & r_req;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_st     <= S_INIT;
         r_addr   <= INIT_ADDR;
         r_req    <= 1'b1;
         r_wr     <= 1'b1;
         r_pend   <= 1'b0;
         r_sdone  <= 1'b0;
         r_wcnt   <= '0;
         r_cursor <= SEG0_FIRST;
         r_ast    <= A_IDLE;
         r_acnt   <= '0;
         r_ack    <= 1'b0;
         r_alarm  <= 1'b0;
         r_stw    <= 1'b0;
      end else begin
         r_st     <= w_st;
         r_addr   <= w_addr;
         r_req    <= w_req;
         r_wr     <= w_wr;
         r_pend   <= w_pend;
         r_sdone  <= w_sdone;
         r_wcnt   <= w_wcnt;
         r_cursor <= w_cursor;
         r_ast    <= w_ast;
         r_acnt   <= w_acnt;
         r_ack    <= w_ack;
         r_alarm  <= w_alarm;
         r_stw    <= w_stw;
      end
   end

   always_comb begin
      w_st    = r_st;
      w_addr  = r_addr;
      w_req   = r_req;
      w_wr    = r_wr;
      w_pend  = r_pend | i_btn_commit;
      w_sdone = 1'b0;
      w_wcnt  = r_wcnt;
      case (r_st)
         S_INIT: if (w_done) begin
            w_st   = S_REQ;
            w_addr = SEG0_FIRST;
            w_wr   = 1'b0;
         end
         S_REQ: if (w_done) begin
            w_st    = S_ADV;
            w_req   = 1'b0;
            w_sdone = (r_addr == SEG1_LAST);
         end
         S_ADV: begin
            w_addr = w_addr_inc;
            if (r_addr == SEG1_LAST) begin
               w_st   = S_WAIT;
               w_wcnt = '0;
            end else begin
               w_st  = S_REQ;
               w_req = 1'b1;
            end
         end
         S_WAIT: begin
            if (r_wcnt == WAIT_LAST) begin
               // Scan write mode is latched here; a commit in this same cycle waits for the next scan.
               w_st   = S_REQ;
               w_req  = 1'b1;
               w_wr   = r_pend;
               w_pend = i_btn_commit;
               w_wcnt = '0;
            end else begin
               w_wcnt = r_wcnt + WCW'(1);
            end
         end
         default: w_st = S_INIT;
      endcase
   end

   always_comb begin
      w_cursor = r_cursor;
      if (i_btn_commit)                   w_cursor = SEG0_FIRST;
      else if (i_btn_left ^ i_btn_right)  w_cursor = w_cur_step;
   end

   always_comb begin
      w_ast  = r_ast;
      w_acnt = r_acnt;
      w_ack  = r_ack;
      w_stw  = 1'b0;
      case (r_ast)
         A_IDLE: if (i_irq) begin
            w_ast  = A_ON;
            w_acnt = '0;
            w_ack  = 1'b0;
         end
         A_ON: begin
            // An ack lets the current cycle finish, then exits on the next one.
            if (r_ack || r_acnt == ALARM_LAST) begin
               w_ast = A_IDLE;
               w_stw = 1'b1;
            end else begin
               w_acnt = r_acnt + ACW'(1);
               w_ack  = i_btn_ack;
            end
         end
         default: w_ast = A_IDLE;
      endcase
      w_alarm = (w_ast == A_ON);
   end

   assign o_req       = r_req;
   assign o_wr        = r_wr;
   assign o_addr      = r_addr;
   assign o_cursor    = r_cursor;
   assign o_scan_done = r_sdone;
   assign o_alarm     = r_alarm;
   assign o_stw       = r_stw;
endmodule

// File: tb/tb_rtc_scan_ctrl.sv
// Directed bench for rtc_scan_ctrl: scan sequencing, commit writes, cursor wrap, alarm, reset.
module tb_rtc_scan_ctrl;
   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       i_done = 1'b0, i_irq = 1'b0;
   logic       i_btn_left = 1'b0, i_btn_right = 1'b0, i_btn_commit = 1'b0, i_btn_ack = 1'b0;
   logic       o_req, o_wr, o_scan_done, o_alarm, o_stw;
   logic [6:0] o_addr, o_cursor;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic       l;
      logic       r;
      logic       c;
      logic [6:0] exp;
   } cur_vec_t;

   cur_vec_t   cv [17];
   logic [6:0] scan_seq [9];

   rtc_scan_ctrl dut (
      .CLK(CLK), .RST(RST), .i_done(i_done), .i_irq(i_irq),
      .i_btn_left(i_btn_left), .i_btn_right(i_btn_right),
      .i_btn_commit(i_btn_commit), .i_btn_ack(i_btn_ack),
      .o_req(o_req), .o_wr(o_wr), .o_addr(o_addr), .o_cursor(o_cursor),
      .o_scan_done(o_scan_done), .o_alarm(o_alarm), .o_stw(o_stw)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   // Acts as the bus driver: three request cycles, then a one-cycle done.
   task automatic serve(input logic [6:0] a, input logic w);
      chk("txn_req", o_req, 1);
      chk("txn_addr", o_addr, a);
      chk("txn_wr", o_wr, w);
      tick;
      chk("txn_hold_addr", o_addr, a);
      tick;
      chk("txn_hold_req", o_req, 1);
      i_done = 1'b1;
      tick;
      i_done = 1'b0;
   endtask

   task automatic run_scan(input logic w, input bit commit, input bit spur);
      for (int i = 0; i < 9; i++) begin
         serve(scan_seq[i], w);
         chk("adv_req_low", o_req, 0);
         chk("adv_scan_done", o_scan_done, (i == 8));
         tick;
      end
      for (int k = 0; k < 5; k++) begin
         chk("wait_req_low", o_req, 0);
         chk("wait_addr", o_addr, 7'h21);
         chk("wait_no_sdone", o_scan_done, 0);
         if (commit && k == 1) i_btn_commit = 1'b1;
         if (spur && k == 2)   i_done = 1'b1;
         tick;
         i_btn_commit = 1'b0;
         i_done = 1'b0;
      end
      chk("wait_end_req", o_req, 1);
      chk("wait_end_addr", o_addr, 7'h21);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      scan_seq = '{7'h21, 7'h22, 7'h23, 7'h24, 7'h25, 7'h26, 7'h41, 7'h42, 7'h43};
      cv[0]  = '{1'b1, 1'b0, 1'b0, 7'h22};
      cv[1]  = '{1'b1, 1'b0, 1'b0, 7'h23};
      cv[2]  = '{1'b1, 1'b0, 1'b0, 7'h24};
      cv[3]  = '{1'b1, 1'b0, 1'b0, 7'h25};
      cv[4]  = '{1'b1, 1'b0, 1'b0, 7'h26};
      cv[5]  = '{1'b1, 1'b0, 1'b0, 7'h41};
      cv[6]  = '{1'b0, 1'b1, 1'b0, 7'h26};
      cv[7]  = '{1'b1, 1'b0, 1'b0, 7'h41};
      cv[8]  = '{1'b1, 1'b1, 1'b0, 7'h41};
      cv[9]  = '{1'b1, 1'b0, 1'b0, 7'h42};
      cv[10] = '{1'b1, 1'b0, 1'b0, 7'h43};
      cv[11] = '{1'b1, 1'b0, 1'b0, 7'h21};
      cv[12] = '{1'b0, 1'b1, 1'b0, 7'h43};
      cv[13] = '{1'b0, 1'b1, 1'b0, 7'h42};
      cv[14] = '{1'b0, 1'b0, 1'b1, 7'h21};
      cv[15] = '{1'b1, 1'b1, 1'b1, 7'h21};
      cv[16] = '{1'b0, 1'b1, 1'b0, 7'h43};

      // Reset state
      tick;
      tick;
      chk("rst_req", o_req, 1);
      chk("rst_wr", o_wr, 1);
      chk("rst_addr", o_addr, 7'h02);
      chk("rst_cursor", o_cursor, 7'h21);
      chk("rst_alarm", o_alarm, 0);
      chk("rst_stw", o_stw, 0);
      chk("rst_sdone", o_scan_done, 0);
      RST = 1'b0;
      tick;

      // Init write, then three scans: commit in first WAIT, spurious done in third WAIT
      serve(7'h02, 1'b1);
      run_scan(1'b0, 1'b1, 1'b0);
      run_scan(1'b1, 1'b0, 1'b0);
      run_scan(1'b0, 1'b0, 1'b1);

      // Cursor table (scan FSM parked in REQ meanwhile)
      for (int i = 0; i < 17; i++) begin
         i_btn_left   = cv[i].l;
         i_btn_right  = cv[i].r;
         i_btn_commit = cv[i].c;
         tick;
         i_btn_left   = 1'b0;
         i_btn_right  = 1'b0;
         i_btn_commit = 1'b0;
         chk($sformatf("cursor_vec%0d", i), o_cursor, cv[i].exp);
      end

      // Alarm: irq pulse, no ack
      chk("alm_idle", o_alarm, 0);
      i_irq = 1'b1;
      tick;
      i_irq = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("alm_on", o_alarm, 1);
         chk("alm_on_stw", o_stw, 0);
         tick;
      end
      chk("alm_exit", o_alarm, 0);
      chk("alm_exit_stw", o_stw, 1);
      tick;
      chk("alm_post_stw", o_stw, 0);
      chk("alm_post", o_alarm, 0);

      // Alarm: ack in first A_ON cycle
      i_irq = 1'b1;
      tick;
      i_irq = 1'b0;
      chk("ack_on1", o_alarm, 1);
      i_btn_ack = 1'b1;
      tick;
      i_btn_ack = 1'b0;
      chk("ack_on2", o_alarm, 1);
      chk("ack_on2_stw", o_stw, 0);
      tick;
      chk("ack_exit", o_alarm, 0);
      chk("ack_exit_stw", o_stw, 1);
      tick;
      chk("ack_post_stw", o_stw, 0);

      // Alarm: irq held high re-enters after one idle cycle
      i_irq = 1'b1;
      tick;
      for (int k = 0; k < 3; k++) begin
         chk("hold_on", o_alarm, 1);
         tick;
      end
      chk("hold_gap", o_alarm, 0);
      chk("hold_gap_stw", o_stw, 1);
      tick;
      chk("hold_reenter", o_alarm, 1);
      chk("hold_reenter_stw", o_stw, 0);
      i_irq = 1'b0;
      tick;
      tick;
      tick;
      chk("hold_exit", o_alarm, 0);
      chk("hold_exit_stw", o_stw, 1);
      tick;

      // Scan in progress keeps wr=0 despite cursor commits; advance to 42
      for (int i = 0; i < 7; i++) begin
         serve(scan_seq[i], 1'b0);
         chk("s4_adv_req", o_req, 0);
         tick;
      end
      chk("pre_rst_addr", o_addr, 7'h42);
      chk("pre_rst_req", o_req, 1);
      i_irq = 1'b1;
      tick;
      i_irq = 1'b0;
      chk("pre_rst_alarm", o_alarm, 1);

      // Asynchronous reset mid-transaction
      #2;
      RST = 1'b1;
      #1;
      chk("arst_addr", o_addr, 7'h02);
      chk("arst_req", o_req, 1);
      chk("arst_wr", o_wr, 1);
      chk("arst_cursor", o_cursor, 7'h21);
      chk("arst_alarm", o_alarm, 0);
      tick;
      chk("rst_next_addr", o_addr, 7'h02);
      chk("rst_next_req", o_req, 1);
      RST = 1'b0;
      tick;
      serve(7'h02, 1'b1);
      chk("post_init_addr", o_addr, 7'h21);
      chk("post_init_req", o_req, 1);
      chk("post_init_wr", o_wr, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rtc_scan_ctrl.md
RTC_SCAN_CTRL -- requirements
Module: rtc_scan_ctrl

Interface
REQ-001 Parameter AW, default 7: address and cursor width.
REQ-002 Parameter INIT_ADDR, default 7'h02: address of the power-up initialisation transaction.
REQ-003 Parameters SEG0_FIRST/SEG0_LAST, default 7'h21/7'h26: first scanned register segment, inclusive.
REQ-004 Parameters SEG1_FIRST/SEG1_LAST, default 7'h41/7'h43: second scanned register segment, inclusive.
REQ-005 Parameters WAIT_CYC, default 5, and ALARM_CYC, default 3: idle gap and alarm duration in cycles, both ≥1.
REQ-006 CLK  in  1  clock; RST  in  1  reset, asynchronous, active-high.
REQ-007 done  in  1  RTC bus driver transaction complete, one-cycle pulse.
REQ-008 irq  in  1  RTC interrupt, level.
REQ-009 btn_left, btn_right, btn_commit, btn_ack  in  1 each  debounced one-cycle button pulses.
REQ-010 req  out  1  transaction request; wr  out  1  1=write, 0=read.
REQ-011 addr  out  AW  transaction address; cursor  out  AW  register under edit.
REQ-012 scan_done  out  1  one-cycle pulse at end of each full scan.
REQ-013 alarm  out  1  alarm active; stw  out  1  one-cycle timer-restart pulse.

Function
REQ-014 Scan FSM states INIT, REQ, ADV, WAIT; all outputs registered.
REQ-015 INIT: req=1, wr=1, addr=INIT_ADDR; on done go to REQ with addr=SEG0_FIRST.
REQ-016 REQ: req=1, addr/wr held stable; on done go to ADV; done sampled while req=0 is ignored.
REQ-017 ADV: req=0 for exactly one cycle; addr advances SEG0_FIRST..SEG0_LAST, then SEG1_FIRST..SEG1_LAST; next state REQ.
REQ-018 After the done for SEG1_LAST: scan_done pulses in the ADV cycle, addr returns to SEG0_FIRST, next state WAIT.
REQ-019 WAIT: req=0 for exactly WAIT_CYC cycles, then REQ.
REQ-020 btn_commit in any state sets a pending-write flag; the next scan starting from WAIT runs with wr=1 for all of its addresses, then the flag clears; a scan in progress keeps its wr value.
REQ-021 Cursor: btn_left +1, btn_right -1, both together no change; btn_commit forces SEG0_FIRST with priority over both.
REQ-022 Cursor wrap: SEG0_LAST+1 -> SEG1_FIRST, SEG1_LAST+1 -> SEG0_FIRST, SEG0_FIRST-1 -> SEG1_LAST, SEG1_FIRST-1 -> SEG0_LAST; cursor never leaves the two segments.
REQ-023 Alarm FSM states A_IDLE, A_ON; A_IDLE -> A_ON when irq=1; alarm=1 in A_ON.
REQ-024 A_ON lasts ALARM_CYC cycles, or ends on the cycle after btn_ack, whichever comes first; stw pulses one cycle at exit either way.
REQ-025 irq in A_ON is ignored; irq still high after exit re-enters A_ON after one A_IDLE cycle.
REQ-026 Cycle counters sized by $clog2 of their parameter +1; no truncation at maximum parameter value.

Reset
REQ-027 RST asynchronous: scan FSM INIT, addr=INIT_ADDR, req=1, wr=1, pending flag 0, cursor=SEG0_FIRST, alarm FSM A_IDLE, alarm=0, stw=0, scan_done=0, counters cleared.
REQ-028 RST mid-transaction abandons it; the next done observed is the one for INIT_ADDR.

Structure
REQ-029 Scan and alarm state encodings and default address constants belong in the shared rtc package.
REQ-030 The segment-wrap address step (+1/-1 with both wrap rules) is the sub-module rtc_addr_step, used by both scan advance and cursor.

Verification
REQ-031 Reset release, done after 3 cycles -> addr sequence 21,22,23,24,25,26,41,42,43 with req low one cycle between each, scan_done once, then 5 idle cycles.
REQ-032 btn_commit during WAIT -> next scan all 9 addresses with wr=1, the following scan wr=0.
REQ-033 Cursor at 26, btn_left -> 41; at 41, btn_right -> 26; at 43, btn_left -> 21; left+right together -> unchanged.
REQ-034 irq pulse, no ack -> alarm high 3 cycles, stw one pulse at exit; btn_ack in the first A_ON cycle -> alarm high 2 cycles, stw one pulse.
REQ-035 RST asserted while addr=42, req=1 -> next cycle addr=02, req=1, wr=1, cursor=21, alarm=0.
REQ-036 Spurious done while req=0 in WAIT -> no addr change, WAIT length unchanged.
